// File: rtl/dilithium_seq_pkg.sv
// Shared types and constants for the dilithium host-side operation sequencer.
package dilithium_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StStart,
    StRun,
    StReport
  } seq_state_t;

  localparam logic [1:0] MODE_KEYGEN = 2'd0;
  localparam logic [1:0] MODE_VERIFY = 2'd1;
  localparam logic [1:0] MODE_SIGN   = 2'd2;

  typedef struct packed {
    logic [31:0] cycles;
    logic [7:0]  rejects;
    logic        timeout;
  } res_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at its all-ones value.
module sat_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/dilithium_op_sequencer.sv
// Drives one dilithium core through reset/start, streams a fixed number of words each way
// with zero added latency, and reports cycles, reject count and timeout per operation.
module dilithium_op_sequencer
  import dilithium_seq_pkg::*;
#(
  parameter int unsigned W       = 64,
  parameter int unsigned CNT_W   = 16,
  parameter logic [31:0] TIMEOUT = 32'd50_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [CNT_W-1:0] cmd_in_words,
  input  logic [CNT_W-1:0] cmd_out_words,
  input  logic             src_valid,
  output logic             src_ready,
  input  logic [W-1:0]     src_data,
  output logic             snk_valid,
  input  logic             snk_ready,
  output logic [W-1:0]     snk_data,
  output logic             core_rst,
  output logic             core_start,
  output logic [1:0]       core_mode,
  input  logic             core_done,
  output logic             core_valid_i,
  input  logic             core_ready_i,
  output logic [W-1:0]     core_data_i,
  input  logic             core_valid_o,
  output logic             core_ready_o,
  input  logic [W-1:0]     core_data_o,
  input  logic [7:0]       core_reject_cnt,
  output logic             busy,
  output logic             res_valid,
  output logic [31:0]      res_cycles,
  output logic [7:0]       res_rejects,
  output logic             res_timeout
);

  seq_state_t       state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] in_words_q, in_words_d, out_words_q, out_words_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  res_t             res_q, res_d;
  logic [31:0]      cyc;

  logic run, in_act, out_act, in_xfer, out_xfer, done_ok, timeout_hit, cmd_fire;

  assign run         = (state_q == StRun);
  assign in_act      = (in_cnt_q < in_words_q);
  assign out_act     = (out_cnt_q < out_words_q);
  assign in_xfer     = run && in_act && src_valid && core_ready_i;
  assign out_xfer    = run && out_act && core_valid_o && snk_ready;
  assign done_ok     = core_done && !in_act && !out_act;
  assign timeout_hit = (TIMEOUT != 32'd0) && (cyc == TIMEOUT - 32'd1);
  assign cmd_ready   = (state_q == StIdle) && !rst;
  assign cmd_fire    = cmd_valid && cmd_ready;

  // Streams are pure wiring gated by the remaining-word counts.
  assign core_valid_i = run && src_valid && in_act;
  assign src_ready    = run && core_ready_i && in_act;
  assign core_data_i  = src_data;
  assign snk_valid    = run && core_valid_o && out_act;
  assign core_ready_o = run && snk_ready && out_act;
  assign snk_data     = core_data_o;

  assign core_rst    = (state_q == StClr);
  assign core_start  = (state_q == StStart);
  assign core_mode   = mode_q;
  assign busy        = (state_q != StIdle);
  assign res_valid   = (state_q == StReport);
  assign res_cycles  = res_valid ? res_q.cycles : 32'd0;
  assign res_rejects = res_valid ? res_q.rejects : 8'd0;
  assign res_timeout = res_valid && res_q.timeout;

  sat_counter #(
    .Width(32)
  ) u_cyc (
    .clk_i(clk),
    .rst_i(rst),
    .clr_i(cmd_fire),
    .en_i ((state_q == StStart) || run),
    .cnt_o(cyc)
  );

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    in_words_d  = in_words_q;
    out_words_d = out_words_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    res_d       = res_q;
    case (state_q)
      StIdle: begin
        if (cmd_fire) begin
          mode_d      = cmd_mode;
          in_words_d  = cmd_in_words;
          out_words_d = cmd_out_words;
          in_cnt_d    = '0;
          out_cnt_d   = '0;
          state_d     = StClr;
        end
      end
      StClr:   state_d = StStart;
      StStart: state_d = StRun;
      StRun: begin
        if (in_xfer)  in_cnt_d  = in_cnt_q + CNT_W'(1);
        if (out_xfer) out_cnt_d = out_cnt_q + CNT_W'(1);
        // Completion takes priority over a coincident timeout.
        if (done_ok || timeout_hit) begin
          res_d.cycles  = cyc;
          res_d.rejects = core_reject_cnt;
          res_d.timeout = !done_ok;
          state_d       = StReport;
        end
      end
      StReport: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      mode_q      <= 2'd0;
      in_words_q  <= '0;
      out_words_q <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      res_q       <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      in_words_q  <= in_words_d;
      out_words_q <= out_words_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      res_q       <= res_d;
    end
  end

endmodule
